pwm_subclock_core: RTL and testbench

//  Prescaled, restartable PWM generator for the SMPS gate-drive path.
//  A divider generates a clock-enable tick every DIVIDER clk cycles.
//  An up-counter advances on each tick and produces a duty-cycle output.
//  All logic runs on one clock (no derived clocks). Several instances with

---
 rtl/pwm_subclock_core_pkg.sv | 19 +
 rtl/pwm_subclock_core_if.sv | 29 ++
 rtl/pwm_subclock_core_clk_en_div.sv | 52 +++++
 rtl/pwm_subclock_core.sv | 75 +++++++
 tb/tb_pwm_subclock_core.sv | 335 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pwm_subclock_core_pkg.sv
// Shared constants and types for the PWM sub-clock core and the
// multi-phase driver controller that instantiates several of them.
package pwm_subclock_core_pkg;

   localparam int DEF_WIDTH   = 8;
   localparam int DEF_DIVIDER = 4;

   typedef logic [DEF_WIDTH-1:0] duty_t;

   // Prescaler register width: a divider of 1 still needs one bit.
   function automatic int presc_width(input int divider);
      if (divider > 1) begin
         return $clog2(divider);
      end else begin
         return 1;
      end
   endfunction

endpackage

// File: rtl/pwm_subclock_core_if.sv
// Control/status bundle of one PWM channel: the controller (master)
// drives restart and duty, the core (slave) returns its strobes and pwm.
interface pwm_subclock_core_if
   import pwm_subclock_core_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
);
   logic             restart;
   logic [WIDTH-1:0] duty;
   logic             tick_o;
   logic             period_o;
   logic             pwm_o;

   modport master (
      output restart,
      output duty,
      input  tick_o,
      input  period_o,
      input  pwm_o
   );

   modport slave (
      input  restart,
      input  duty,
      output tick_o,
      output period_o,
      output pwm_o
   );
endinterface

// File: rtl/pwm_subclock_core_clk_en_div.sv
// Clock-enable divider: counts 0..DIVIDER-1 and flags the wrap.
// en is the same-cycle advance strobe for the counter in the parent;
// tick is its registered copy, visible the cycle after the wrap edge.
module clk_en_div
   import pwm_subclock_core_pkg::*;
#(
   parameter int DIVIDER = DEF_DIVIDER
)(
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   output logic en,
   output logic tick
);
   localparam int            PW   = presc_width(DIVIDER);
   localparam logic [PW-1:0] LAST = PW'(DIVIDER - 1);

   logic [PW-1:0] presc_r;
   logic [PW-1:0] presc_next_s;
   logic          en_s;
   logic          tick_r;

   // Next prescaler value; clear wins over the wrap so no enable leaks out.
   always_comb begin
      presc_next_s = presc_r;
      en_s         = 1'b0;
      if (clr) begin
         presc_next_s = {PW{1'b0}};
         en_s         = 1'b0;
      end else if (presc_r == LAST) begin
         presc_next_s = {PW{1'b0}};
         en_s         = 1'b1;
      end else begin
         presc_next_s = presc_r + PW'(1);
         en_s         = 1'b0;
      end
   end

   // Prescaler state and registered tick strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_r <= {PW{1'b0}};
         tick_r  <= 1'b0;
      end else begin
         presc_r <= presc_next_s;
         tick_r  <= en_s;
      end
   end

   assign en   = en_s;
   assign tick = tick_r;
endmodule

// File: rtl/pwm_subclock_core.sv
// Prescaled, restartable PWM generator. The period counter advances once
// per prescaler wrap; the duty shadow is reloaded only at a period
// boundary (wrap or restart) so mid-period duty writes never glitch pwm_o.
module pwm_subclock_core
   import pwm_subclock_core_pkg::*;
#(
   parameter int DIVIDER = DEF_DIVIDER,
   parameter int WIDTH   = DEF_WIDTH
)(
   input  logic               clk,
   input  logic               rst_n,
   pwm_subclock_core_if.slave bus
);
   localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

   logic             en_s;
   logic             tick_s;
   logic [WIDTH-1:0] cnt_r;
   logic [WIDTH-1:0] cnt_next_s;
   logic [WIDTH-1:0] duty_sh_r;
   logic [WIDTH-1:0] duty_sh_next_s;
   logic             wrap_s;
   logic             period_r;
   logic             pwm_r;

   clk_en_div #(
      .DIVIDER (DIVIDER)
   ) u_div (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (bus.restart),
      .en    (en_s),
      .tick  (tick_s)
   );

   // Counter and duty-shadow next state; restart outranks a coincident wrap.
   always_comb begin
      cnt_next_s     = cnt_r;
      duty_sh_next_s = duty_sh_r;
      wrap_s         = 1'b0;
      if (bus.restart) begin
         cnt_next_s     = {WIDTH{1'b0}};
         duty_sh_next_s = bus.duty;
      end else if (en_s) begin
         if (cnt_r == CNT_MAX) begin
            cnt_next_s     = {WIDTH{1'b0}};
            duty_sh_next_s = bus.duty;
            wrap_s         = 1'b1;
         end else begin
            cnt_next_s = cnt_r + WIDTH'(1);
         end
      end else begin
         cnt_next_s = cnt_r;
      end
   end

   // State and outputs; pwm compares next-state values so it has no lag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r     <= {WIDTH{1'b0}};
         duty_sh_r <= {WIDTH{1'b0}};
         period_r  <= 1'b0;
         pwm_r     <= 1'b0;
      end else begin
         cnt_r     <= cnt_next_s;
         duty_sh_r <= duty_sh_next_s;
         period_r  <= wrap_s;
         pwm_r     <= (cnt_next_s < duty_sh_next_s);
      end
   end

   assign bus.tick_o   = tick_s;
   assign bus.period_o = period_r;
   assign bus.pwm_o    = pwm_r;
endmodule

// File: tb/tb_pwm_subclock_core.sv
// Bench for pwm_subclock_core: dut0 uses DIVIDER=4, dut1 uses DIVIDER=1.
// A monitor measures each full period of dut0 (high clks, length, ticks)
// into a queue; tests push the expected window and compare in order.
module tb_pwm_subclock_core;
   import pwm_subclock_core_pkg::*;

   typedef struct {
      int hi;
      int len;
      int ticks;
   } win_t;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   win_t exp_q[$];
   win_t meas_q[$];
   int   mon_hi = 0;
   int   mon_len = 0;
   int   mon_ticks = 0;
   bit   win_valid = 1'b0;

   pwm_subclock_core_if #(.WIDTH(8)) bus0 ();
   pwm_subclock_core_if #(.WIDTH(8)) bus1 ();

   pwm_subclock_core #(.DIVIDER(4), .WIDTH(8)) dut0 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus0)
   );

   pwm_subclock_core #(.DIVIDER(1), .WIDTH(8)) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1)
   );

   always #5 clk = ~clk;

   // Window monitor for dut0: a window runs from one period_o to the next.
   always @(negedge clk) begin
      win_t w;
      if (bus0.period_o === 1'b1) begin
         if (win_valid) begin
            w.hi    = mon_hi;
            w.len   = mon_len;
            w.ticks = mon_ticks;
            meas_q.push_back(w);
         end
         mon_hi    = (bus0.pwm_o === 1'b1) ? 1 : 0;
         mon_len   = 1;
         mon_ticks = (bus0.tick_o === 1'b1) ? 1 : 0;
         win_valid = 1'b1;
      end else begin
         mon_len++;
         if (bus0.pwm_o === 1'b1) mon_hi++;
         if (bus0.tick_o === 1'b1) mon_ticks++;
      end
      if (rst_n !== 1'b1 || bus0.restart === 1'b1) win_valid = 1'b0;
   end

   task automatic wait_period(input int which, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 1300; c++) begin
         @(posedge clk); #1;
         if ((which == 0 && bus0.period_o === 1'b1) ||
             (which == 1 && bus1.period_o === 1'b1)) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic restart0(input logic [7:0] d);
      @(posedge clk); #1;
      bus0.duty    = d;
      bus0.restart = 1'b1;
      @(posedge clk); #1;
      bus0.restart = 1'b0;
   endtask

   task automatic test_reset;
      int n;
      rst_n = 1'b0;
      bus0.restart = 1'b0; bus0.duty = 8'd0;
      bus1.restart = 1'b0; bus1.duty = 8'd0;
      repeat (3) @(posedge clk); #1;
      checks++;
      if ({bus0.tick_o, bus0.period_o, bus0.pwm_o} !== 3'b000) begin
         errors++;
         $display("FAIL reset_idle got %b need 000", {bus0.tick_o, bus0.period_o, bus0.pwm_o});
      end
      @(negedge clk) rst_n = 1'b1;
      restart0(8'd102);
      checks++;
      if (bus0.pwm_o !== 1'b1) begin
         errors++;
         $display("FAIL restart_pwm_hi got %b need 1", bus0.pwm_o);
      end
      repeat (5) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      checks++;
      if ({bus0.tick_o, bus0.period_o, bus0.pwm_o, bus1.tick_o, bus1.period_o, bus1.pwm_o} !== 6'b000000) begin
         errors++;
         $display("FAIL reset_async got %b need 000000",
                  {bus0.tick_o, bus0.period_o, bus0.pwm_o, bus1.tick_o, bus1.period_o, bus1.pwm_o});
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         n = 0;
         for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            n++;
            if (bus0.tick_o === 1'b1) break;
         end
         checks++;
         if (n !== 4) begin
            errors++;
            $display("FAIL tick_spacing_%0d got %0d clks need 4", k, n);
         end
      end
   endtask

   task automatic test_duty;
      bit   ok;
      win_t e;
      win_t m;
      restart0(8'd102);
      meas_q.delete();
      exp_q.delete();
      e.hi = 408; e.len = 1024; e.ticks = 256; exp_q.push_back(e);
      wait_period(0, ok);
      bus0.duty = 8'd0;
      e.hi = 0; exp_q.push_back(e);
      wait_period(0, ok);
      bus0.duty = 8'd255;
      e.hi = 1020; exp_q.push_back(e);
      for (int c = 0; c < 5000 && meas_q.size() < 3; c++) @(posedge clk);
      checks++;
      if (meas_q.size() < 3) begin
         errors++;
         $display("FAIL duty_windows got %0d windows need 3", meas_q.size());
      end
      while (exp_q.size() > 0 && meas_q.size() > 0) begin
         e = exp_q.pop_front();
         m = meas_q.pop_front();
         checks += 3;
         if (m.hi !== e.hi) begin
            errors++; $display("FAIL duty_high got %0d need %0d", m.hi, e.hi);
         end
         if (m.len !== e.len) begin
            errors++; $display("FAIL duty_period_len got %0d need %0d", m.len, e.len);
         end
         if (m.ticks !== e.ticks) begin
            errors++; $display("FAIL duty_ticks got %0d need %0d", m.ticks, e.ticks);
         end
      end
   endtask

   task automatic test_mid_change;
      bit   ok;
      int   n;
      win_t e;
      win_t m;
      restart0(8'd102);
      meas_q.delete();
      exp_q.delete();
      wait_period(0, ok);
      n = 0;
      for (int c = 0; c < 400 && n < 50; c++) begin
         @(posedge clk); #1;
         if (bus0.tick_o === 1'b1) n++;
      end
      bus0.duty = 8'd200;
      e.hi = 408; e.len = 1024; e.ticks = 256; exp_q.push_back(e);
      e.hi = 800; exp_q.push_back(e);
      for (int c = 0; c < 3000 && meas_q.size() < 2; c++) @(posedge clk);
      checks++;
      if (meas_q.size() < 2) begin
         errors++;
         $display("FAIL mid_windows got %0d windows need 2", meas_q.size());
      end
      while (exp_q.size() > 0 && meas_q.size() > 0) begin
         e = exp_q.pop_front();
         m = meas_q.pop_front();
         checks += 2;
         if (m.hi !== e.hi) begin
            errors++; $display("FAIL mid_high got %0d need %0d", m.hi, e.hi);
         end
         if (m.len !== e.len) begin
            errors++; $display("FAIL mid_period_len got %0d need %0d", m.len, e.len);
         end
      end
   endtask

   task automatic test_restart;
      bit   ok;
      int   n;
      int   first_tick;
      win_t e;
      win_t m;
      restart0(8'd102);
      exp_q.delete();
      wait_period(0, ok);
      n = 0;
      for (int c = 0; c < 800 && n < 150; c++) begin
         @(posedge clk); #1;
         if (bus0.tick_o === 1'b1) n++;
      end
      // The edge after these three would normally raise tick_o.
      repeat (3) @(posedge clk); #1;
      bus0.duty    = 8'd60;
      bus0.restart = 1'b1;
      @(posedge clk); #1;
      bus0.restart = 1'b0;
      meas_q.delete();
      checks += 3;
      if (bus0.tick_o !== 1'b0) begin
         errors++; $display("FAIL restart_tick got %b need 0", bus0.tick_o);
      end
      if (bus0.period_o !== 1'b0) begin
         errors++; $display("FAIL restart_period got %b need 0", bus0.period_o);
      end
      if (bus0.pwm_o !== 1'b1) begin
         errors++; $display("FAIL restart_reload_pwm got %b need 1", bus0.pwm_o);
      end
      first_tick = 0;
      n = 0;
      for (int c = 0; c < 1300; c++) begin
         @(posedge clk); #1;
         n++;
         if (bus0.tick_o === 1'b1 && first_tick == 0) first_tick = n;
         if (bus0.period_o === 1'b1) break;
      end
      checks += 2;
      if (first_tick !== 4) begin
         errors++; $display("FAIL restart_first_tick got %0d clks need 4", first_tick);
      end
      if (n !== 1024) begin
         errors++; $display("FAIL restart_to_wrap got %0d clks need 1024", n);
      end
      e.hi = 240; e.len = 1024; e.ticks = 256; exp_q.push_back(e);
      for (int c = 0; c < 3000 && meas_q.size() < 1; c++) @(posedge clk);
      checks++;
      if (meas_q.size() < 1) begin
         errors++;
         $display("FAIL restart_windows got %0d windows need 1", meas_q.size());
      end else begin
         e = exp_q.pop_front();
         m = meas_q.pop_front();
         checks++;
         if (m.hi !== e.hi) begin
            errors++; $display("FAIL restart_high got %0d need %0d", m.hi, e.hi);
         end
      end
   endtask

   task automatic test_div1;
      bit ok;
      int n;
      int hi;
      int lows;
      @(posedge clk); #1;
      bus1.duty    = 8'd64;
      bus1.restart = 1'b1;
      @(posedge clk); #1;
      bus1.restart = 1'b0;
      checks++;
      if (bus1.tick_o !== 1'b0) begin
         errors++; $display("FAIL div1_restart_tick got %b need 0", bus1.tick_o);
      end
      lows = 0;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         if (bus1.tick_o !== 1'b1) lows++;
      end
      checks++;
      if (lows !== 0) begin
         errors++; $display("FAIL div1_tick_const got %0d low cycles need 0", lows);
      end
      wait_period(1, ok);
      checks++;
      if (!ok) begin
         errors++; $display("FAIL div1_first_wrap got none need one");
      end
      n = 0;
      hi = (bus1.pwm_o === 1'b1) ? 1 : 0;
      for (int c = 0; c < 600; c++) begin
         @(posedge clk); #1;
         n++;
         if (bus1.period_o === 1'b1) break;
         if (bus1.pwm_o === 1'b1) hi++;
      end
      checks += 2;
      if (n !== 256) begin
         errors++; $display("FAIL div1_period got %0d clks need 256", n);
      end
      if (hi !== 64) begin
         errors++; $display("FAIL div1_high got %0d clks need 64", hi);
      end
      // Restart lands exactly on the edge that would wrap the counter.
      repeat (255) @(posedge clk); #1;
      bus1.restart = 1'b1;
      @(posedge clk); #1;
      bus1.restart = 1'b0;
      checks++;
      if (bus1.period_o !== 1'b0) begin
         errors++; $display("FAIL div1_restart_wins got %b need 0", bus1.period_o);
      end
      n = 0;
      for (int c = 0; c < 600; c++) begin
         @(posedge clk); #1;
         n++;
         if (bus1.period_o === 1'b1) break;
      end
      checks++;
      if (n !== 256) begin
         errors++; $display("FAIL div1_after_restart got %0d clks need 256", n);
      end
   endtask

   initial begin
      test_reset();
      test_duty();
      test_mid_change();
      test_restart();
      test_div1();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
